lmg_move_unpacker: RTL and testbench
====================================

// Module: lmg_move_unpacker
// PURPOSE
//  Sits between the LMG output FIFO and the move-list writer in control.
//  Pops packed 8-slot LMG words, drops invalid slots and streams valid
//  moves one per beat over a valid/ready handshake, with a running index.
//  An all-invalid word is the end-of-list marker: the block raises
//  list_done and reports the total move count.
// PARAMETERS
//  MOVE_W  18  width of one move field (bits [MOVE_W-1:0] of a slot)
//  SLOTS   8   move slots per LMG word; slot width is MOVE_W+1, the MSB is the invalid flag
//  CNT_W   8   width of move_index / move_count
// PORTS
//  clk           in   1                single clock, rising edge
//  reset_n       in   1                asynchronous, active-low reset
//  start         in   1                1-cycle pulse: clear state, begin a new list
//  lmg_done      in   1                LMG has finished and its FIFO is readable
//  lmg_rden      out  1                1-cycle FIFO pop request
//  lmg_fifo_out  in   SLOTS*(MOVE_W+1) packed word; slot k = bits [k*(MOVE_W+1) +: MOVE_W+1]
//  move_valid    out  1                move_data / move_index are valid
//  move_ready    in   1                consumer accepts this beat
//  move_data     out  MOVE_W           current move (slot bits [MOVE_W-1:0])
//  move_index    out  CNT_W            0-based index of the current move
//  move_count    out  CNT_W            number of moves accepted so far
//  list_done     out  1                end-of-list seen; held until the next start
//  overflow      out  1                sticky: more than 2^CNT_W-1 moves were accepted
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=IDLE. lmg_rden, move_valid, list_done
//    and overflow = 0. move_data, move_index, move_count and the slot mask = 0.
//  - FIFO timing: the word on lmg_fifo_out is valid exactly 1 cycle after
//    the lmg_rden pulse.
//  - States:
//    IDLE:  outputs idle. start -> WAIT.
//    WAIT:  lmg_done=1 -> POP. Otherwise stay in WAIT.
//    POP:   lmg_rden=1 for this 1 cycle -> LATCH.
//    LATCH: register the word. mask[k] = ~invalid bit of slot k.
//           mask==0 -> FIN. Otherwise -> EMIT.
//    EMIT:  move_valid=1. move_data = lowest-index slot with mask set.
//           move_index = move_count.
//           On valid&&ready: clear that mask bit and increment move_count.
//           If the mask becomes 0 -> POP (next cycle), else stay in EMIT.
//    FIN:   list_done=1, move_valid=0, move_count frozen. start -> WAIT.
//  - move_valid must not drop, and move_data must not change, while
//    move_ready=0 (AXI-style stability).
//  - Throughput: 1 move per cycle in EMIT while move_ready=1.
//    Per-word overhead: 2 cycles (POP, LATCH).
//  - Count arithmetic: move_count saturates at 2^CNT_W-1.
//    An accept while the count is saturated sets overflow. The move is
//    still emitted; move_index stays at the saturated value.
//  - A start pulse in any state (including mid-EMIT) aborts the current
//    list: mask, move_count, list_done and overflow all clear; -> WAIT.
//    start takes priority over a same-cycle handshake.
//  - lmg_done dropping outside WAIT is ignored.
//    Another lmg_rden is issued only after the current word is drained.
//  - Partially valid words (for example only slots 0 and 5 valid) emit
//    only the valid slots, in ascending slot order.
//  - reset_n asserted mid-operation returns the block to IDLE
//    immediately; no FIFO pop is in flight after reset.
// TESTING
//  1. Reset, start, lmg_done=1; word 0 has all 8 slots valid with moves
//     1..8, word 1 is all-invalid; ready=1
//     -> 8 beats with data 1..8 and index 0..7 on consecutive cycles,
//     then list_done=1 and move_count=8.
//  2. Word with only slots 2 and 7 valid (0xA, 0xB), then all-invalid
//     -> exactly 2 beats (0xA idx0, 0xB idx1); list_done=1; move_count=2.
//  3. move_ready toggling 1,0,0,1,...
//     -> data and index stay stable while ready=0; no move lost or
//     duplicated; move_count is correct at list_done.
//  4. First word all-invalid -> no move_valid; list_done=1 two cycles
//     after the pop; move_count=0.
//  5. CNT_W=3, 10 valid moves -> move_count saturates at 7; overflow=1
//     from the 8th accept onward; all 10 beats are delivered.
//  6. start pulse mid-EMIT (after 3 beats) -> move_valid drops next
//     cycle and move_count=0. A fresh list then runs correctly. Also:
//     reset_n=0 for 1 cycle mid-EMIT -> all outputs take reset values.

Source files
------------

// File: rtl/lmg_move_unpacker.sv
// Unpacks 8-slot LMG FIFO words into a valid/ready stream of moves with a running index.
// An all-invalid word ends the list and freezes the move count.

module lmg_slot_decode #(
  parameter int MOVE_W = 18
) (
  input  logic [MOVE_W:0]   slot,
  output logic              vld,
  output logic [MOVE_W-1:0] move
);
  assign vld  = ~slot[MOVE_W];
  assign move = slot[MOVE_W-1:0];
endmodule

module lmg_move_unpacker #(
  parameter int MOVE_W = 18,
  parameter int SLOTS  = 8,
  parameter int CNT_W  = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic                        lmg_done,
  output logic                        lmg_rden,
  input  logic [SLOTS*(MOVE_W+1)-1:0] lmg_fifo_out,
  output logic                        move_valid,
  input  logic                        move_ready,
  output logic [MOVE_W-1:0]           move_data,
  output logic [CNT_W-1:0]            move_index,
  output logic [CNT_W-1:0]            move_count,
  output logic                        list_done,
  output logic                        overflow
);
  localparam int SW = MOVE_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_POP, S_LATCH, S_EMIT, S_FIN} state_t;

  state_t                         state, state_nxt;
  logic [SLOTS-1:0]               mask, mask_in, low_bit;
  logic [SLOTS-1:0][MOVE_W-1:0]   moves, moves_in;
  logic [MOVE_W-1:0]              sel_data;
  logic                           found;

  for (genvar k = 0; k < SLOTS; k++) begin : g_slot
    lmg_slot_decode #(.MOVE_W(MOVE_W)) u_dec (
      .slot (lmg_fifo_out[k*SW +: SW]),
      .vld  (mask_in[k]),
      .move (moves_in[k])
    );
  end

  // Lowest pending slot wins; data reads as zero when nothing is pending.
  always_comb begin
    low_bit  = '0;
    sel_data = '0;
    found    = 1'b0;
    for (int k = 0; k < SLOTS; k++) begin
      if (mask[k] && !found) begin
        low_bit[k] = 1'b1;
        sel_data   = moves[k];
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (start) state_nxt = S_WAIT;
    else begin
      case (state)
        S_IDLE:  state_nxt = S_IDLE;
        S_WAIT:  if (lmg_done) state_nxt = S_POP;
        S_POP:   state_nxt = S_LATCH;
        S_LATCH: state_nxt = (mask_in == '0) ? S_FIN : S_EMIT;
        S_EMIT:  if (move_ready && (mask & ~low_bit) == '0) state_nxt = S_POP;
        S_FIN:   state_nxt = S_FIN;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      mask       <= '0;
      moves      <= '0;
      move_count <= '0;
      overflow   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        mask       <= '0;
        move_count <= '0;
        overflow   <= 1'b0;
      end else if (state == S_LATCH) begin
        mask  <= mask_in;
        moves <= moves_in;
      end else if (state == S_EMIT && move_ready) begin
        mask <= mask & ~low_bit;
        // Count pins at its maximum; further accepts only flag overflow.
        if (move_count == CNT_MAX) overflow <= 1'b1;
        else move_count <= move_count + CNT_W'(1);
      end
    end
  end

  assign lmg_rden   = (state == S_POP);
  assign move_valid = (state == S_EMIT);
  assign list_done  = (state == S_FIN);
  assign move_data  = sel_data;
  assign move_index = move_count;

endmodule

// File: tb/tb_lmg_move_unpacker.sv
// Directed bench for lmg_move_unpacker: a word FIFO model feeds two instances
// (CNT_W=8 and CNT_W=3) driven in lockstep.

module tb_lmg_move_unpacker;
  localparam int MW = 18;
  localparam int WW = 8 * (MW + 1);

  logic clk = 1'b0;
  logic reset_n, start, lmg_done, move_ready;
  logic [WW-1:0] lmg_fifo_out;
  logic lmg_rden, move_valid, list_done, overflow;
  logic [MW-1:0] move_data;
  logic [7:0] move_index, move_count;
  logic lmg_rden3, move_valid3, list_done3, overflow3;
  logic [MW-1:0] move_data3;
  logic [2:0] move_index3, move_count3;

  lmg_move_unpacker #(.MOVE_W(MW), .SLOTS(8), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .lmg_done(lmg_done),
    .lmg_rden(lmg_rden), .lmg_fifo_out(lmg_fifo_out), .move_valid(move_valid),
    .move_ready(move_ready), .move_data(move_data), .move_index(move_index),
    .move_count(move_count), .list_done(list_done), .overflow(overflow));

  lmg_move_unpacker #(.MOVE_W(MW), .SLOTS(8), .CNT_W(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .start(start), .lmg_done(lmg_done),
    .lmg_rden(lmg_rden3), .lmg_fifo_out(lmg_fifo_out), .move_valid(move_valid3),
    .move_ready(move_ready), .move_data(move_data3), .move_index(move_index3),
    .move_count(move_count3), .list_done(list_done3), .overflow(overflow3));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [WW-1:0] fifo_q[$];
  logic [WW-1:0] all_inv;
  initial all_inv = '1;

  // Popped word appears on the FIFO output one cycle after the read pulse.
  always @(posedge clk) begin
    logic [WW-1:0] w;
    if (lmg_rden) begin
      w = (fifo_q.size() > 0) ? fifo_q.pop_front() : all_inv;
      lmg_fifo_out <= w;
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  int nb, stall_err, pop_cyc, done_cyc;
  logic [MW-1:0] got_data[32];
  logic [7:0]    got_idx[32];
  logic [2:0]    got_idx3[32];
  logic          got_ovf3[32];
  int            got_cyc[32];

  function automatic logic [WW-1:0] mk_word(input logic [7:0] vm, input logic [7:0][MW-1:0] v);
    logic [WW-1:0] w;
    w = '0;
    for (int k = 0; k < 8; k++) w[k*(MW+1) +: MW+1] = vm[k] ? {1'b0, v[k]} : {1'b1, {MW{1'b1}}};
    return w;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Gathers accepted beats until list_done, checking stall stability along the way.
  task automatic collect(input logic [3:0] pat, input int plen);
    logic held;
    logic [MW-1:0] hd;
    logic [7:0] hi;
    nb = 0; stall_err = 0; pop_cyc = -1; done_cyc = -1; held = 1'b0; hd = '0; hi = '0;
    for (int i = 0; i < 300; i++) begin
      move_ready = pat[i % plen];
      if (lmg_rden) pop_cyc = cyc;
      if (held && (!move_valid || move_data !== hd || move_index !== hi)) stall_err++;
      held = 1'b0;
      if (move_valid) begin
        if (move_ready) begin
          if (nb < 32) begin
            got_data[nb] = move_data; got_idx[nb] = move_index;
            got_idx3[nb] = move_index3; got_ovf3[nb] = overflow3; got_cyc[nb] = cyc;
          end
          nb++;
        end else begin
          held = 1'b1; hd = move_data; hi = move_index;
        end
      end
      if (list_done) begin done_cyc = cyc; break; end
      @(posedge clk); #1;
    end
    n_checks++;
    if (done_cyc < 0) begin n_fail++; $display("FAIL collect_timeout: list_done never seen within 300 cycles"); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; lmg_done = 1'b0; move_ready = 1'b0; lmg_fifo_out = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if ({lmg_rden, move_valid, list_done, overflow} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {lmg_rden, move_valid, list_done, overflow}); end
    n_checks++; if (move_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", move_data); end
    n_checks++; if ({move_index, move_count} !== 16'h0) begin n_fail++; $display("FAIL reset_counts: got %h want 0000", {move_index, move_count}); end
    n_checks++; if ({move_valid3, overflow3, move_count3} !== 5'b0) begin n_fail++; $display("FAIL reset_dut3: got %b want 00000", {move_valid3, overflow3, move_count3}); end
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if ({lmg_rden, move_valid} !== 2'b0) begin n_fail++; $display("FAIL idle_after_reset: got %b want 00", {lmg_rden, move_valid}); end
  endtask

  task automatic test_full_word();
    logic [7:0][MW-1:0] v;
    logic busy;
    for (int k = 0; k < 8; k++) v[k] = MW'(k + 1);
    fifo_q.push_back(mk_word(8'hFF, v));
    fifo_q.push_back(all_inv);
    pulse_start();
    busy = 1'b0;
    repeat (3) begin
      if (lmg_rden || move_valid) busy = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wait_no_done: got activity %b want 0", busy); end
    lmg_done = 1'b1;
    collect(4'b0001, 1);
    n_checks++; if (nb !== 8) begin n_fail++; $display("FAIL full_beats: got %0d want 8", nb); end
    for (int k = 0; k < 8 && k < nb; k++) begin
      n_checks++; if (got_data[k] !== MW'(k + 1) || got_idx[k] !== 8'(k) || got_cyc[k] !== got_cyc[0] + k) begin
        n_fail++; $display("FAIL full_beat%0d: got data %h idx %0d cyc+%0d want %h %0d +%0d", k, got_data[k], got_idx[k], got_cyc[k] - got_cyc[0], k + 1, k, k);
      end
    end
    n_checks++; if (list_done !== 1'b1 || move_count !== 8'd8) begin n_fail++; $display("FAIL full_done: got done %b count %0d want 1 8", list_done, move_count); end
  endtask

  task automatic test_partial_word();
    logic [7:0][MW-1:0] v;
    v = '0; v[2] = MW'(18'hA); v[7] = MW'(18'hB);
    fifo_q.push_back(mk_word(8'b1000_0100, v));
    fifo_q.push_back(all_inv);
    pulse_start();
    collect(4'b0001, 1);
    n_checks++; if (nb !== 2) begin n_fail++; $display("FAIL partial_beats: got %0d want 2", nb); end
    n_checks++; if (got_data[0] !== MW'(18'hA) || got_idx[0] !== 8'd0) begin n_fail++; $display("FAIL partial_beat0: got %h/%0d want a/0", got_data[0], got_idx[0]); end
    n_checks++; if (got_data[1] !== MW'(18'hB) || got_idx[1] !== 8'd1) begin n_fail++; $display("FAIL partial_beat1: got %h/%0d want b/1", got_data[1], got_idx[1]); end
    n_checks++; if (list_done !== 1'b1 || move_count !== 8'd2) begin n_fail++; $display("FAIL partial_done: got done %b count %0d want 1 2", list_done, move_count); end
  endtask

  task automatic test_backpressure();
    logic [7:0][MW-1:0] v;
    logic [MW-1:0] exp;
    for (int k = 0; k < 8; k++) v[k] = MW'(18'h100 + k);
    fifo_q.push_back(mk_word(8'hFF, v));
    v = '0; v[0] = MW'(18'h200); v[5] = MW'(18'h205);
    fifo_q.push_back(mk_word(8'b0010_0001, v));
    fifo_q.push_back(all_inv);
    pulse_start();
    collect(4'b1001, 4);
    n_checks++; if (nb !== 10) begin n_fail++; $display("FAIL bp_beats: got %0d want 10", nb); end
    n_checks++; if (stall_err !== 0) begin n_fail++; $display("FAIL bp_stability: got %0d unstable stall cycles want 0", stall_err); end
    for (int k = 0; k < 10 && k < nb; k++) begin
      exp = (k < 8) ? MW'(18'h100 + k) : (k == 8 ? MW'(18'h200) : MW'(18'h205));
      n_checks++; if (got_data[k] !== exp || got_idx[k] !== 8'(k)) begin
        n_fail++; $display("FAIL bp_beat%0d: got %h/%0d want %h/%0d", k, got_data[k], got_idx[k], exp, k);
      end
    end
    n_checks++; if (move_count !== 8'd10) begin n_fail++; $display("FAIL bp_count: got %0d want 10", move_count); end
  endtask

  task automatic test_empty_list();
    fifo_q.push_back(all_inv);
    pulse_start();
    collect(4'b0001, 1);
    n_checks++; if (nb !== 0) begin n_fail++; $display("FAIL empty_beats: got %0d want 0", nb); end
    n_checks++; if (done_cyc - pop_cyc !== 2) begin n_fail++; $display("FAIL empty_latency: got %0d cycles want 2", done_cyc - pop_cyc); end
    n_checks++; if (move_count !== 8'd0) begin n_fail++; $display("FAIL empty_count: got %0d want 0", move_count); end
  endtask

  task automatic test_saturation();
    logic [7:0][MW-1:0] v;
    for (int k = 0; k < 8; k++) v[k] = MW'(k + 1);
    fifo_q.push_back(mk_word(8'hFF, v));
    v = '0; v[0] = MW'(9); v[1] = MW'(10);
    fifo_q.push_back(mk_word(8'b0000_0011, v));
    fifo_q.push_back(all_inv);
    pulse_start();
    collect(4'b0001, 1);
    n_checks++; if (nb !== 10) begin n_fail++; $display("FAIL sat_beats: got %0d want 10", nb); end
    for (int k = 0; k < 10 && k < nb; k++) begin
      n_checks++; if (got_data[k] !== MW'(k + 1) || got_idx3[k] !== 3'((k < 7) ? k : 7) || got_ovf3[k] !== (k >= 8)) begin
        n_fail++; $display("FAIL sat_beat%0d: got data %0d idx3 %0d ovf %b want %0d %0d %b", k, got_data[k], got_idx3[k], got_ovf3[k], k + 1, (k < 7) ? k : 7, k >= 8);
      end
    end
    n_checks++; if (move_count3 !== 3'd7 || overflow3 !== 1'b1) begin n_fail++; $display("FAIL sat_final3: got count %0d ovf %b want 7 1", move_count3, overflow3); end
    n_checks++; if (move_count !== 8'd10 || overflow !== 1'b0) begin n_fail++; $display("FAIL sat_final8: got count %0d ovf %b want 10 0", move_count, overflow); end
  endtask

  task automatic test_abort();
    logic [7:0][MW-1:0] v;
    int acc;
    logic aborted, busy;
    for (int k = 0; k < 8; k++) v[k] = MW'(18'h30 + k);
    fifo_q.push_back(mk_word(8'hFF, v));
    pulse_start();
    acc = 0; aborted = 1'b0;
    for (int i = 0; i < 50; i++) begin
      move_ready = 1'b1;
      if (move_valid && acc == 3) begin
        v = '0; v[0] = MW'(18'h51); v[1] = MW'(18'h52);
        fifo_q.push_back(mk_word(8'b0000_0011, v));
        fifo_q.push_back(all_inv);
        start = 1'b1; aborted = 1'b1;
        break;
      end
      if (move_valid) acc++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++; if (aborted !== 1'b1) begin n_fail++; $display("FAIL abort_reached: got %b want 1", aborted); end
    n_checks++; if ({move_valid, list_done, overflow} !== 3'b0 || move_count !== 8'd0) begin
      n_fail++; $display("FAIL abort_clear: got valid/done/ovf %b count %0d want 000 0", {move_valid, list_done, overflow}, move_count);
    end
    collect(4'b0001, 1);
    n_checks++; if (nb !== 2 || got_data[0] !== MW'(18'h51) || got_data[1] !== MW'(18'h52) || got_idx[1] !== 8'd1) begin
      n_fail++; $display("FAIL abort_fresh: got %0d beats %h %h idx1 %0d want 2 51 52 1", nb, got_data[0], got_data[1], got_idx[1]);
    end
    n_checks++; if (move_count !== 8'd2) begin n_fail++; $display("FAIL abort_fresh_count: got %0d want 2", move_count); end

    for (int k = 0; k < 8; k++) v[k] = MW'(18'h60 + k);
    fifo_q.push_back(mk_word(8'hFF, v));
    pulse_start();
    acc = 0;
    for (int i = 0; i < 50 && acc < 2; i++) begin
      move_ready = 1'b1;
      if (move_valid) acc++;
      @(posedge clk); #1;
    end
    reset_n = 1'b0;
    #1;
    n_checks++; if ({lmg_rden, move_valid, list_done, overflow} !== 4'b0 || move_data !== '0) begin
      n_fail++; $display("FAIL midreset_flags: got %b data %h want 0000 0", {lmg_rden, move_valid, list_done, overflow}, move_data);
    end
    n_checks++; if ({move_index, move_count} !== 16'h0) begin n_fail++; $display("FAIL midreset_counts: got %h want 0000", {move_index, move_count}); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    busy = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (lmg_rden || move_valid || list_done) busy = 1'b1;
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_idle: got activity %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_partial_word();
    test_backpressure();
    test_empty_list();
    test_saturation();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
